fas_normalize_pack: RTL and testbench

Final stage of the floating-point add/sub pipeline. It takes the signed-magnitude sum from the adder stage: sign, 32-bit magnitude and the 9-bit base exponent produced by the alignment stage. It normalises, rounds to nearest-even and packs the result into an IEEE-754 single-precision word. It is a two-stage pipeline with a valid pulse and flushes subnormals to zero.

---
 rtl/fas_normalize_pack_if.sv | 23 ++
 rtl/fas_normalize_pack.sv | 162 ++++++++++++++++
 tb/tb_fas_normalize_pack.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fas_normalize_pack_if.sv
// Bus between the adder stage and the normalise/round/pack stage.
interface fas_normalize_pack_if;
  logic [32:0] sum_in;
  logic [8:0]  base_e;
  logic        in_valid;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        out_valid;

  // Producer side: drives the signed-magnitude sum, observes the packed result.
  modport master (
    output sum_in, base_e, in_valid,
    input  result, overflow, underflow, inexact, out_valid
  );

  // Normaliser side.
  modport slave (
    input  sum_in, base_e, in_valid,
    output result, overflow, underflow, inexact, out_valid
  );
endinterface

// File: rtl/fas_normalize_pack.sv
// Final add/sub stage: normalise a signed-magnitude sum, round to nearest-even
// and pack into IEEE-754 single precision. Two register stages, subnormals
// flushed to signed zero, results held while out_valid is low.
module fas_normalize_pack #(
  parameter int unsigned BIAS  = 127,
  parameter int unsigned POINT = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  fas_normalize_pack_if.slave  bus
);

  localparam int unsigned MAG_W  = 32;
  localparam int unsigned LEAD_W = 5;
  localparam int unsigned E_W    = 11;
  localparam int unsigned FRAC_W = 23;

  // Largest biased exponent (all ones) encodes infinity.
  localparam logic signed [E_W-1:0] E_MAX   = E_W'(2 * BIAS + 1);
  localparam logic signed [E_W-1:0] E_ZERO  = '0;
  localparam logic signed [E_W-1:0] E_POINT = E_W'(POINT);

  // ---------------------------------------------------------------------------
  // Stage 1: leading-one detect, left-justify, exponent adjust
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0]      mag_c;
  logic [LEAD_W-1:0]     lead_c;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q,  s1_sign_d;
  logic [MAG_W-1:0]      s1_norm_q,  s1_norm_d;
  logic signed [E_W-1:0] s1_exp_q,   s1_exp_d;

  assign mag_c = bus.sum_in[MAG_W-1:0];

  // Index of the highest set magnitude bit (0 when the magnitude is zero).
  always_comb begin
    lead_c = '0;
    for (int i = 0; i < int'(MAG_W); i++) begin
      if (mag_c[i]) lead_c = LEAD_W'(i);
    end
  end

  // Stage-1 next state; holds unless a new operand is qualified.
  always_comb begin
    s1_valid_d = bus.in_valid;
    s1_sign_d  = s1_sign_q;
    s1_norm_d  = s1_norm_q;
    s1_exp_d   = s1_exp_q;
    if (bus.in_valid) begin
      s1_sign_d = bus.sum_in[MAG_W];
      s1_norm_d = mag_c << (LEAD_W'(MAG_W - 1) - lead_c);
      s1_exp_d  = E_W'(bus.base_e) + E_W'(lead_c) - E_POINT;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_norm_q  <= '0;
      s1_exp_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_norm_q  <= s1_norm_d;
      s1_exp_q   <= s1_exp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round to nearest-even, classify, pack
  // ---------------------------------------------------------------------------
  logic                  zero_c;
  logic [FRAC_W-1:0]     frac_c;
  logic                  guard_c;
  logic                  sticky_c;
  logic                  lsb_c;
  logic                  round_up_c;
  logic [FRAC_W:0]       frac_inc_c;
  logic                  carry_c;
  logic [FRAC_W-1:0]     frac_rnd_c;
  logic signed [E_W-1:0] exp_rnd_c;

  logic [31:0]           result_q,    result_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  inexact_q,   inexact_d;
  logic                  out_valid_q, out_valid_d;

  // Rounding datapath; a zero magnitude is the only case with no leading one.
  always_comb begin
    zero_c     = ~s1_norm_q[MAG_W-1];
    frac_c     = s1_norm_q[MAG_W-2:8];
    guard_c    = s1_norm_q[7];
    sticky_c   = |s1_norm_q[6:0];
    lsb_c      = s1_norm_q[8];
    round_up_c = guard_c & (sticky_c | lsb_c);
    frac_inc_c = {1'b0, frac_c} + (FRAC_W + 1)'(round_up_c);
    carry_c    = frac_inc_c[FRAC_W];
    frac_rnd_c = carry_c ? '0 : frac_inc_c[FRAC_W-1:0];
    exp_rnd_c  = s1_exp_q + E_W'(carry_c);
  end

  // Stage-2 next state. Overflow uses the rounded exponent; flush-to-zero
  // uses the exponent before rounding, so a round-up out of E=0 still flushes.
  always_comb begin
    out_valid_d = s1_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    if (s1_valid_q) begin
      if (zero_c) begin
        result_d    = 32'h0000_0000;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = 1'b0;
      end else if (exp_rnd_c >= E_MAX) begin
        result_d    = {s1_sign_q, 8'hFF, 23'h0};
        overflow_d  = 1'b1;
        underflow_d = 1'b0;
        inexact_d   = 1'b1;
      end else if (s1_exp_q <= E_ZERO) begin
        result_d    = {s1_sign_q, 31'h0};
        overflow_d  = 1'b0;
        underflow_d = 1'b1;
        inexact_d   = 1'b1;
      end else begin
        result_d    = {s1_sign_q, exp_rnd_c[7:0], frac_rnd_c};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = guard_c | sticky_c;
      end
    end
  end

  // Stage-2 / output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fas_normalize_pack.sv
// Self-checking bench for fas_normalize_pack: directed vectors plus a
// randomized stream compared against an arithmetic reference model.
module tb_fas_normalize_pack;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fas_normalize_pack_if bus ();

  fas_normalize_pack #(.BIAS(127), .POINT(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        s;
    logic [31:0] mag;
    logic [8:0]  e;
    logic [31:0] r;
    logic [2:0]  f;   // {overflow, underflow, inexact}
  } vec_t;

  // Reference: value = (-1)^s * mag * 2^(e-127-30); keep 24 significant bits,
  // round the discarded part to nearest-even by comparing it with one half ulp.
  function automatic void model(input logic s, input logic [31:0] mag, input int e,
                                output logic [31:0] r, output logic [2:0] f);
    int p, ep, epost;
    longint unsigned m, kept, dropped, half;
    if (mag == 32'd0) begin
      r = 32'h0;
      f = 3'b000;
      return;
    end
    p = 31;
    while (mag[p] == 1'b0) p--;
    ep = e + p - 30;
    m  = 64'(mag);
    if (p > 23) begin
      kept    = m >> (p - 23);
      dropped = m & ((64'd1 << (p - 23)) - 64'd1);
      half    = 64'd1 << (p - 24);
      if (dropped > half || (dropped == half && kept[0])) kept++;
    end else begin
      kept    = m << (23 - p);
      dropped = 64'd0;
    end
    epost = ep;
    if (kept == (64'd1 << 24)) begin
      kept  = kept >> 1;
      epost = ep + 1;
    end
    if (epost >= 255) begin
      r = {s, 8'hFF, 23'h0};
      f = 3'b101;
    end else if (ep <= 0) begin
      r = {s, 31'h0};
      f = 3'b011;
    end else begin
      r = {s, 8'(epost), 23'(kept)};
      f = {2'b00, dropped != 64'd0};
    end
  endfunction

  // Drive one qualified operand for a single cycle and return when its
  // result should be visible (one time unit after the second following edge).
  task automatic send(input logic s, input logic [31:0] mag, input logic [8:0] e);
    @(posedge clk); #1;
    bus.sum_in   = {s, mag};
    bus.base_e   = e;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
    vectors++;
    if (got !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", got, 36'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    vec_t tv[5];
    logic [35:0] got, exp;
    tv = '{'{1'b0, 32'h4000_0000, 9'd127, 32'h3F80_0000, 3'b000},
           '{1'b0, 32'h6000_0000, 9'd128, 32'h4040_0000, 3'b000},
           '{1'b0, 32'h8000_0000, 9'd127, 32'h4000_0000, 3'b000},
           '{1'b0, 32'h0000_0001, 9'd157, 32'h3F80_0000, 3'b000},
           '{1'b1, 32'h4000_0000, 9'd127, 32'hBF80_0000, 3'b000}};
    foreach (tv[i]) begin
      send(tv[i].s, tv[i].mag, tv[i].e);
      got = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
      exp = {1'b1, tv[i].r, tv[i].f};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL normal[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t tv[4];
    logic [35:0] got, exp;
    tv = '{'{1'b0, 32'h4000_0040, 9'd127, 32'h3F80_0000, 3'b001},
           '{1'b0, 32'h4000_00C0, 9'd127, 32'h3F80_0002, 3'b001},
           '{1'b0, 32'h7FFF_FFC0, 9'd127, 32'h4000_0000, 3'b001},
           '{1'b0, 32'h4000_0041, 9'd127, 32'h3F80_0001, 3'b001}};
    foreach (tv[i]) begin
      send(tv[i].s, tv[i].mag, tv[i].e);
      got = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
      exp = {1'b1, tv[i].r, tv[i].f};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rounding[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_exceptions();
    vec_t tv[8];
    logic [35:0] got, exp;
    tv = '{'{1'b0, 32'h4000_0000, 9'd255, 32'h7F80_0000, 3'b101},
           '{1'b1, 32'h4000_0000, 9'd0,   32'h8000_0000, 3'b011},
           '{1'b1, 32'h0000_0000, 9'd127, 32'h0000_0000, 3'b000},
           '{1'b0, 32'h7FFF_FFC0, 9'd0,   32'h0000_0000, 3'b011},
           '{1'b1, 32'h7FFF_FFC0, 9'd254, 32'hFF80_0000, 3'b101},
           '{1'b0, 32'h4000_0000, 9'd1,   32'h0080_0000, 3'b000},
           '{1'b0, 32'h4000_0000, 9'd254, 32'h7F00_0000, 3'b000},
           '{1'b0, 32'hFFFF_FFFF, 9'd511, 32'h7F80_0000, 3'b101}};
    foreach (tv[i]) begin
      send(tv[i].s, tv[i].mag, tv[i].e);
      got = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
      exp = {1'b1, tv[i].r, tv[i].f};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL exception[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv[4];
    logic [35:0] got, exp;
    tv = '{'{1'b0, 32'h4000_0000, 9'd127, 32'h3F80_0000, 3'b000},
           '{1'b0, 32'h6000_0000, 9'd128, 32'h4040_0000, 3'b000},
           '{1'b0, 32'h8000_0000, 9'd127, 32'h4000_0000, 3'b000},
           '{1'b1, 32'h4000_0000, 9'd127, 32'hBF80_0000, 3'b000}};
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      got = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
      if (c >= 2 && c < 6) begin
        exp = {1'b1, tv[c-2].r, tv[c-2].f};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL stream[%0d]: got %h expected %h", c - 2, got, exp);
        end
      end else if (c >= 6) begin
        exp = {1'b0, tv[3].r, tv[3].f};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL hold[%0d]: got %h expected %h", c - 6, got, exp);
        end
      end
      if (c < 4) begin
        bus.sum_in   = {tv[c].s, tv[c].mag};
        bus.base_e   = tv[c].e;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [32:0] got;
    logic [35:0] got2, exp2;
    @(posedge clk); #1;
    bus.sum_in   = {1'b0, 32'h6000_0000};
    bus.base_e   = 9'd128;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      got = {bus.out_valid, bus.result};
      vectors++;
      if (got !== 33'h0) begin
        miscompares++;
        $display("FAIL reset_midflight[%0d]: got %h expected %h", c, got, 33'h0);
      end
      @(posedge clk); #1;
    end
    send(1'b1, 32'h0000_0001, 9'd158);
    got2 = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
    exp2 = {1'b1, 32'hC000_0000, 3'b000};
    vectors++;
    if (got2 !== exp2) begin
      miscompares++;
      $display("FAIL after_reset: got %h expected %h", got2, exp2);
    end
  endtask

  task automatic test_random();
    logic        d1_v, d2_v;
    logic [31:0] d1_r, d2_r, last_r;
    logic [2:0]  d1_f, d2_f, last_f;
    logic [35:0] got, exp;
    logic        s, v;
    logic [31:0] mag;
    logic [8:0]  e;
    logic [31:0] mr;
    logic [2:0]  mf;
    rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    d1_v   = 1'b0;
    d2_v   = 1'b0;
    d1_r   = '0; d1_f = '0; d2_r = '0; d2_f = '0;
    last_r = '0;
    last_f = '0;
    for (int it = 0; it < 402; it++) begin
      @(posedge clk); #1;
      got = {bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact};
      if (d2_v) begin
        last_r = d2_r;
        last_f = d2_f;
      end
      exp = {d2_v, last_r, last_f};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", it, got, exp);
      end
      d2_v = d1_v; d2_r = d1_r; d2_f = d1_f;
      v = (it < 400) && ($urandom_range(0, 9) < 7);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       mag = 32'h0;
        1:       mag = $urandom >> $urandom_range(0, 31);
        2:       mag = {2'b01, 23'($urandom), 7'h40};
        3:       mag = 32'hFFFF_FFFF >> $urandom_range(0, 8);
        default: mag = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       e = 9'($urandom_range(0, 6));
        1:       e = 9'($urandom_range(248, 260));
        2:       e = 9'($urandom_range(480, 511));
        default: e = 9'($urandom_range(20, 250));
      endcase
      model(s, mag, int'(e), mr, mf);
      d1_v = v; d1_r = mr; d1_f = mf;
      bus.sum_in   = {s, mag};
      bus.base_e   = e;
      bus.in_valid = v;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.sum_in   = '0;
    bus.base_e   = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_normal();
    test_rounding();
    test_exceptions();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
